seg_display_fetch: RTL and testbench

Seven-segment scan controller that reads the segment lookup table (words 0–15 of data memory, active-high patterns with segment a in bit 0) over the data-memory read port. It time-multiplexes four hex digits of a 16-bit value onto a common-anode display. The block sits beside the CPU as a second memory initiator: it requests the port through a req/gnt handshake, issues one word read per digit refresh, and drives registered anode and segment outputs.

---
 rtl/seg_display_pkg.sv | 14 +
 rtl/seg_display_fetch_divider.sv | 29 ++
 rtl/seg_display_fetch.sv | 137 +++++++++++++
 tb/tb_seg_display_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_display_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    FETCH = 2'd1,
    SHOW  = 2'd2
  } state_t;

  localparam logic [3:0]  ANODE_OFF         = 4'hF;
  localparam logic [6:0]  SEG_OFF           = 7'h7F;
  localparam logic [31:0] TABLE_ENTRY_BYTES = 32'd4;

endpackage

// File: rtl/seg_display_fetch_divider.sv
// Free-running digit-slot divider: asserts tick for one cycle every REFRESH_DIV clocks.
module refresh_divider
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_display_fetch.sv
// Seven-segment scan controller fetching digit patterns from data memory.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module seg_display_fetch
  import seg_display_pkg::*;
#(
  parameter int          REFRESH_DIV = 50000,
  parameter logic [31:0] TABLE_BASE  = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n
);

  logic tick;

  refresh_divider #(.REFRESH_DIV(REFRESH_DIV)) u_divider (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_t      state, state_nxt;
  logic [1:0]  dig, dig_nxt;
  logic [3:0]  nib, nib_nxt;
  logic [6:0]  pat, pat_nxt;
  logic        blank, blank_nxt;
  logic        req_nxt;
  logic [31:0] addr_nxt;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;

  logic [1:0]  dig_inc;
  logic [3:0]  nib_sel;
  logic        blank_sel;

  // Upper read-data bits carry no segment information.
  logic        unused_rdata;
  assign unused_rdata = ^mem_rdata[31:7];

  assign dig_inc = dig + 2'd1;
  assign nib_sel = value[{dig_inc, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    blank_sel = 1'b0;
    case (dig_inc)
      2'd1:    blank_sel = (value[15:4]  == 12'h000);
      2'd2:    blank_sel = (value[15:8]  == 8'h00);
      2'd3:    blank_sel = (value[15:12] == 4'h0);
      default: blank_sel = 1'b0;
    endcase
  end
`else
  assign blank_sel = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    dig_nxt   = dig;
    nib_nxt   = nib;
    pat_nxt   = pat;
    blank_nxt = blank;
    req_nxt   = 1'b0;
    addr_nxt  = 32'h0;
    an_nxt    = an_n;
    seg_nxt   = seg_n;

    case (state)
      WAIT: begin
        if (tick) begin
          dig_nxt   = dig_inc;
          nib_nxt   = nib_sel;
          blank_nxt = blank_sel;
          if (blank_sel) begin
            state_nxt = SHOW;
          end else begin
            state_nxt = FETCH;
            req_nxt   = 1'b1;
            addr_nxt  = TABLE_BASE + (32'(nib_sel) * TABLE_ENTRY_BYTES);
          end
        end
      end
      FETCH: begin
        if (mem_gnt) begin
          pat_nxt   = mem_rdata[6:0];
          state_nxt = SHOW;
        end else begin
          // Hold the request steady until the arbiter grants it.
          req_nxt  = 1'b1;
          addr_nxt = mem_addr;
        end
      end
      SHOW: begin
        an_nxt    = ~(4'b0001 << dig);
        seg_nxt   = blank ? SEG_OFF : ~pat;
        state_nxt = WAIT;
      end
      default: begin
        state_nxt = WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WAIT;
      dig      <= 2'd3;
      nib      <= 4'h0;
      pat      <= 7'h00;
      blank    <= 1'b0;
      mem_req  <= 1'b0;
      mem_read <= 1'b0;
      mem_addr <= 32'h0;
      an_n     <= ANODE_OFF;
      seg_n    <= SEG_OFF;
    end else begin
      state    <= state_nxt;
      dig      <= dig_nxt;
      nib      <= nib_nxt;
      pat      <= pat_nxt;
      blank    <= blank_nxt;
      mem_req  <= req_nxt;
      mem_read <= req_nxt;
      mem_addr <= addr_nxt;
      an_n     <= an_nxt;
      seg_n    <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_display_fetch.sv
// Scoreboard bench for seg_display_fetch; the model predicts fetch addresses and display updates with their cycle.
module tb_seg_display_fetch;

  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h00000000;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'h1A2F;
  logic        mem_gnt = 1'b1;
  logic        mem_req, mem_read;
  logic [31:0] mem_addr, mem_rdata;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int vectors = 0;
  int miscompares = 0;
  int nupd = 0;

  always #5 clk = ~clk;

  seg_display_fetch #(.REFRESH_DIV(DIV), .TABLE_BASE(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .mem_req   (mem_req),
    .mem_gnt   (mem_gnt),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata),
    .an_n      (an_n),
    .seg_n     (seg_n)
  );

  // Memory model: table entries in bits [6:0], junk above.
  logic [31:0] off;
  assign off       = mem_addr - BASE;
  assign mem_rdata = {JUNK[31:7], tbl[off[5:2]]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit blank_of(input logic [15:0] v, input int d);
    bit en;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    return en && (d != 0) && ((v >> (4 * d)) == 16'h0);
  endfunction

  // Reference model: display slots as a stream of events with time stamps.
  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         at;
  } disp_t;

  disp_t       dq[$];
  logic [31:0] fq[$];
  int          cyc;
  bit          m_fetch;
  logic [31:0] m_addr;
  int          busy_until;
  int          m_dig;
  logic [3:0]  m_nib;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc = 0; m_fetch = 0; m_addr = 0; busy_until = 0; m_dig = 3; m_nib = 0;
      dq.delete(); fq.delete();
    end else begin : model_step
      bit acc, cap;
      disp_t e;
      cyc++;
      acc = ((cyc % DIV) == 0) && !m_fetch && (cyc > busy_until);
      cap = m_fetch && mem_gnt;
      if (cap) begin
        m_fetch = 0;
        busy_until = cyc + 1;
        e.an = 4'hF ^ (4'b0001 << m_dig);
        e.seg = ~tbl[m_nib];
        e.at = cyc + 1;
        dq.push_back(e);
      end
      if (acc) begin
        m_dig = (m_dig + 1) % 4;
        m_nib = 4'((value >> (4 * m_dig)) & 16'hF);
        if (blank_of(value, m_dig)) begin
          busy_until = cyc + 1;
          e.an = 4'hF ^ (4'b0001 << m_dig);
          e.seg = 7'h7F;
          e.at = cyc + 1;
          dq.push_back(e);
        end else begin
          m_fetch = 1;
          m_addr = BASE + 32'(m_nib) * 32'd4;
          fq.push_back(m_addr);
        end
      end
    end
  end

  // Monitor: compares bus behaviour each cycle and pops expectations on handshakes and display updates.
  logic [10:0] prev;
  always @(negedge clk) begin
    if (reset) begin
      prev = {an_n, seg_n};
    end else begin
      chk("mem_req", {31'b0, mem_req}, {31'b0, m_fetch});
      chk("mem_read", {31'b0, mem_read}, {31'b0, m_fetch});
      chk("mem_addr", mem_addr, m_fetch ? m_addr : 32'h0);
      if (mem_req && mem_gnt) begin
        if (fq.size() == 0) chk("fetch_unexpected", 32'd1, 32'd0);
        else chk("fetch_addr", mem_addr, fq.pop_front());
      end
      if ({an_n, seg_n} !== prev) begin
        if (dq.size() == 0) begin
          chk("display_unexpected", {21'b0, an_n, seg_n}, {21'b0, prev});
        end else begin : pop_disp
          disp_t e;
          e = dq.pop_front();
          chk("an_n", {28'b0, an_n}, {28'b0, e.an});
          chk("seg_n", {25'b0, seg_n}, {25'b0, e.seg});
          chk("update_cycle", cyc, e.at);
        end
        nupd++;
        prev = {an_n, seg_n};
      end
    end
  end

  function automatic logic [15:0] rand_value();
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 5))
      0: return r;
      1: return r >> 4;
      2: return r >> 8;
      3: return r >> 12;
      4: return 16'h0007;
      default: return 16'h0000;
    endcase
  endfunction

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    chk("reset_an_n", {28'b0, an_n}, 32'hF);
    chk("reset_seg_n", {25'b0, seg_n}, 32'h7F);
    chk("reset_mem_req", {31'b0, mem_req}, 32'h0);
    chk("reset_mem_read", {31'b0, mem_read}, 32'h0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1 reset = 1'b0;

    // Directed value with grant tied high, more than four slots to see the wrap.
    repeat (24) @(posedge clk);

    // Grant delay: stall a fetch for five cycles.
    #1 mem_gnt = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1 found = mem_req;
    end
    chk("stall_req_seen", {31'b0, found}, 32'd1);
    repeat (5) @(posedge clk);
    #1 mem_gnt = 1'b1;
    repeat (12) @(posedge clk);

    // Spurious grants while no request is outstanding.
    repeat (30) begin
      @(posedge clk); #1 mem_gnt = mem_req ? 1'b1 : 1'($urandom_range(0, 1));
    end

    repeat (1500) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 7) == 0) value = rand_value();
      mem_gnt = ($urandom_range(0, 99) < 60);
    end

    // Reset while a fetch is waiting for grant.
    mem_gnt = 1'b0;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1 found = mem_req;
    end
    chk("midfetch_req_seen", {31'b0, found}, 32'd1);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("midreset_mem_req", {31'b0, mem_req}, 32'h0);
    chk("midreset_mem_read", {31'b0, mem_read}, 32'h0);
    chk("midreset_an_n", {28'b0, an_n}, 32'hF);
    chk("midreset_seg_n", {25'b0, seg_n}, 32'h7F);
    @(posedge clk); #1 reset = 1'b0;
    value = 16'h0007;
    mem_gnt = 1'b1;
    repeat (30) @(posedge clk);

    repeat (500) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 5) == 0) value = rand_value();
      mem_gnt = ($urandom_range(0, 99) < 70);
    end

    @(negedge clk);
    chk("updates_seen", {31'b0, (nupd > 100)}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
